// File: rtl/sc_regplayer_pos.sv
// Player-position register: a PLAYER_WIDTH-bit lit block inside a DATAWIDTH-bit row,
// moved by level button requests with press detection and hold-to-repeat timing.
// Define SC_REGPLAYER_WRAP_EN for wrap-around edges; the default build clamps at the row ends.
`timescale 1ns/1ps
module sc_regplayer_pos #(
  parameter int DATAWIDTH     = 8,
  parameter int PLAYER_WIDTH  = 2,
  parameter int INIT_POS      = 3,
  parameter int REPEAT_DELAY  = 16,
  parameter int REPEAT_PERIOD = 4
) (
  input  logic                         SC_REGPLAYER_CLOCK_50,
  input  logic                         SC_REGPLAYER_RESET_InHigh,
  input  logic                         SC_REGPLAYER_clear_InLow,
  input  logic                         SC_REGPLAYER_left_In,
  input  logic                         SC_REGPLAYER_right_In,
  input  logic                         SC_REGPLAYER_load_In,
  input  logic [$clog2(DATAWIDTH)-1:0] SC_REGPLAYER_loadpos_InBUS,
  output logic [DATAWIDTH-1:0]         SC_REGPLAYER_data_OutBUS,
  output logic [$clog2(DATAWIDTH)-1:0] SC_REGPLAYER_pos_OutBUS,
  output logic                         SC_REGPLAYER_atleft_Out,
  output logic                         SC_REGPLAYER_atright_Out,
  output logic                         SC_REGPLAYER_moved_Out
);

  localparam int PW      = $clog2(DATAWIDTH);
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW      = $clog2(CNT_MAX);

`ifdef SC_REGPLAYER_WRAP_EN
  localparam logic [PW-1:0] POS_MAX = PW'(DATAWIDTH - 1);
`else
  localparam logic [PW-1:0] POS_MAX = PW'(DATAWIDTH - PLAYER_WIDTH);
`endif
  localparam logic [PW-1:0] POS_INIT    = PW'(INIT_POS);
  localparam logic [CW-1:0] DELAY_LOAD  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PERIOD_LOAD = CW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_e;

  rep_state_e              state_r, state_nxt_s;
  logic [CW-1:0]           cnt_r, cnt_nxt_s;
  logic [PW-1:0]           pos_r, pos_nxt_s, step_pos_s;
  logic                    visible_r, vis_nxt_s;
  logic                    moved_r, moved_nxt_s;
  logic [1:0]              prev_dir_r, dir_s;
  logic                    step_s;
  logic [DATAWIDTH-1:0]    data_r, data_nxt_s;

  // Row pattern for a given position; indices past the MSB fold back to the LSB side.
  function automatic logic [DATAWIDTH-1:0] row_pattern(input logic [PW-1:0] p, input logic vis);
    logic [DATAWIDTH-1:0] r;
    logic [31:0]          idx;
    r = {DATAWIDTH{1'b0}};
    for (int i = 0; i < PLAYER_WIDTH; i++) begin
      idx = 32'(p) + 32'(i);
      if (idx >= 32'(DATAWIDTH)) begin
        idx = idx - 32'(DATAWIDTH);
      end else begin
        idx = idx;
      end
      r[idx[PW-1:0]] = vis;
    end
    return r;
  endfunction

  // Bit 1 = left, bit 0 = right; both or neither pressed means no direction.
  assign dir_s = {SC_REGPLAYER_left_In & ~SC_REGPLAYER_right_In,
                  SC_REGPLAYER_right_In & ~SC_REGPLAYER_left_In};

  // State register.
  always_ff @(posedge SC_REGPLAYER_CLOCK_50) begin
    if (SC_REGPLAYER_RESET_InHigh) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {CW{1'b0}};
      pos_r      <= POS_INIT;
      visible_r  <= 1'b1;
      moved_r    <= 1'b0;
      prev_dir_r <= 2'b00;
      data_r     <= row_pattern(POS_INIT, 1'b1);
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      pos_r      <= pos_nxt_s;
      visible_r  <= vis_nxt_s;
      moved_r    <= moved_nxt_s;
      prev_dir_r <= dir_s;
      data_r     <= data_nxt_s;
    end
  end

  // Repeat FSM next state: a direction change restarts as a fresh press.
  always_comb begin
    state_nxt_s = ST_IDLE;
    cnt_nxt_s   = {CW{1'b0}};
    step_s      = 1'b0;
    if (!SC_REGPLAYER_clear_InLow || SC_REGPLAYER_load_In || !visible_r || (dir_s == 2'b00)) begin
      state_nxt_s = ST_IDLE;
      cnt_nxt_s   = {CW{1'b0}};
    end else if ((state_r == ST_IDLE) || (dir_s != prev_dir_r)) begin
      step_s      = 1'b1;
      cnt_nxt_s   = DELAY_LOAD;
      state_nxt_s = ST_DELAY;
    end else begin
      case (state_r)
        ST_DELAY, ST_REPEAT: begin
          if (cnt_r == {CW{1'b0}}) begin
            step_s      = 1'b1;
            cnt_nxt_s   = PERIOD_LOAD;
            state_nxt_s = ST_REPEAT;
          end else begin
            cnt_nxt_s   = cnt_r - CW'(1);
            state_nxt_s = state_r;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = {CW{1'b0}};
        end
      endcase
    end
  end

  // Candidate position for one step in the requested direction.
  always_comb begin
    step_pos_s = pos_r;
    if (dir_s[1]) begin
`ifdef SC_REGPLAYER_WRAP_EN
      step_pos_s = (pos_r == POS_MAX) ? {PW{1'b0}} : pos_r + PW'(1);
`else
      step_pos_s = (pos_r == POS_MAX) ? pos_r : pos_r + PW'(1);
`endif
    end else if (dir_s[0]) begin
`ifdef SC_REGPLAYER_WRAP_EN
      step_pos_s = (pos_r == {PW{1'b0}}) ? POS_MAX : pos_r - PW'(1);
`else
      step_pos_s = (pos_r == {PW{1'b0}}) ? pos_r : pos_r - PW'(1);
`endif
    end else begin
      step_pos_s = pos_r;
    end
  end

  // Output next values: clear beats load beats move.
  always_comb begin
    pos_nxt_s   = pos_r;
    vis_nxt_s   = visible_r;
    moved_nxt_s = 1'b0;
    if (!SC_REGPLAYER_clear_InLow) begin
      pos_nxt_s = POS_INIT;
      vis_nxt_s = 1'b0;
    end else if (SC_REGPLAYER_load_In) begin
      pos_nxt_s = (SC_REGPLAYER_loadpos_InBUS > POS_MAX) ? POS_MAX : SC_REGPLAYER_loadpos_InBUS;
      vis_nxt_s = 1'b1;
    end else if (step_s) begin
      pos_nxt_s   = step_pos_s;
      moved_nxt_s = (step_pos_s != pos_r);
    end else begin
      pos_nxt_s = pos_r;
    end
    data_nxt_s = row_pattern(pos_nxt_s, vis_nxt_s);
  end

  assign SC_REGPLAYER_data_OutBUS = data_r;
  assign SC_REGPLAYER_pos_OutBUS  = pos_r;
  assign SC_REGPLAYER_moved_Out   = moved_r;
`ifdef SC_REGPLAYER_WRAP_EN
  assign SC_REGPLAYER_atleft_Out  = 1'b0;
  assign SC_REGPLAYER_atright_Out = 1'b0;
`else
  assign SC_REGPLAYER_atleft_Out  = (pos_r == POS_MAX);
  assign SC_REGPLAYER_atright_Out = (pos_r == {PW{1'b0}});
`endif

endmodule

// File: tb/tb_sc_regplayer_pos.sv
// Bench for sc_regplayer_pos: constant vector table, hand-built hold/reset sequences,
// then random stimulus against a hold-duration reference model.
`timescale 1ns/1ps
module tb_sc_regplayer_pos;

  localparam int DW  = 8;
  localparam int PLW = 2;
  localparam int IP  = 3;
  localparam int RD  = 16;
  localparam int RP  = 4;
  localparam int PW  = 3;
`ifdef SC_REGPLAYER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif
  localparam int POSMAX = WRAP ? DW - 1 : DW - PLW;

  logic          clk = 1'b0;
  logic          rst, clr_n, left, right, load;
  logic [PW-1:0] lpos;
  logic [DW-1:0] data_o;
  logic [PW-1:0] pos_o;
  logic          atl_o, atr_o, moved_o;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: position, visibility, length of the current held run, last direction
  int m_pos, m_vis, m_run, m_prev, m_moved;

  sc_regplayer_pos #(
    .DATAWIDTH(DW), .PLAYER_WIDTH(PLW), .INIT_POS(IP),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .SC_REGPLAYER_CLOCK_50      (clk),
    .SC_REGPLAYER_RESET_InHigh  (rst),
    .SC_REGPLAYER_clear_InLow   (clr_n),
    .SC_REGPLAYER_left_In       (left),
    .SC_REGPLAYER_right_In      (right),
    .SC_REGPLAYER_load_In       (load),
    .SC_REGPLAYER_loadpos_InBUS (lpos),
    .SC_REGPLAYER_data_OutBUS   (data_o),
    .SC_REGPLAYER_pos_OutBUS    (pos_o),
    .SC_REGPLAYER_atleft_Out    (atl_o),
    .SC_REGPLAYER_atright_Out   (atr_o),
    .SC_REGPLAYER_moved_Out     (moved_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst; bit clr_n; bit l; bit r; bit ld; int lp;
    int e_pos; int e_data; bit e_moved;
  } vec_t;

  function automatic vec_t mk(bit rs, bit cn, bit l, bit r, bit ld, int lp, int ep, int ed, bit em);
    vec_t v;
    v.rst = rs; v.clr_n = cn; v.l = l; v.r = r; v.ld = ld; v.lp = lp;
    v.e_pos = ep; v.e_data = ed; v.e_moved = em;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int exp_data();
    int d = 0;
    for (int b = 0; b < DW; b++)
      if (m_vis != 0 && ((b - m_pos + DW) % DW) < PLW) d = d | (1 << b);
    return d;
  endfunction

  // A move is due on the first cycle of a hold, at RD, then every RP cycles.
  task automatic model_edge(input bit rs, input bit cn, input bit l, input bit r, input bit ld, input int lp);
    int dir, np;
    dir = (l && !r) ? 2 : ((r && !l) ? 1 : 0);
    if (rs) begin
      m_pos = IP; m_vis = 1; m_run = -1; m_moved = 0;
    end else if (!cn) begin
      m_pos = IP; m_vis = 0; m_run = -1; m_moved = 0;
    end else if (ld) begin
      m_pos = (lp > POSMAX) ? POSMAX : lp; m_vis = 1; m_run = -1; m_moved = 0;
    end else if (dir != 0 && m_vis != 0) begin
      if (dir != m_prev || m_run < 0) m_run = 0;
      else m_run = m_run + 1;
      m_moved = 0;
      if (m_run == 0 || (m_run >= RD && ((m_run - RD) % RP) == 0)) begin
        np = (dir == 2) ? m_pos + 1 : m_pos - 1;
        if (WRAP) np = (np + DW) % DW;
        else if (np < 0 || np > POSMAX) np = m_pos;
        m_moved = (np != m_pos) ? 1 : 0;
        m_pos = np;
      end
    end else begin
      m_run = -1; m_moved = 0;
    end
    m_prev = rs ? 0 : dir;
  endtask

  task automatic cycle(input bit rs, input bit cn, input bit l, input bit r, input bit ld, input int lp, input string tag);
    rst = rs; clr_n = cn; left = l; right = r; load = ld; lpos = lp[PW-1:0];
    @(posedge clk);
    model_edge(rs, cn, l, r, ld, lp);
    #1;
    chk({tag, "/pos"},   32'(pos_o),   m_pos);
    chk({tag, "/data"},  32'(data_o),  exp_data());
    chk({tag, "/moved"}, 32'(moved_o), m_moved);
    chk({tag, "/atl"},   32'(atl_o),   (!WRAP && m_pos == POSMAX) ? 1 : 0);
    chk({tag, "/atr"},   32'(atr_o),   (!WRAP && m_pos == 0) ? 1 : 0);
  endtask

  vec_t tbl[$];
  int   mask, exp_mask, cnt, hold_pos, dir;

  initial begin
    rst = 1'b1; clr_n = 1'b1; left = 1'b0; right = 1'b0; load = 1'b0; lpos = '0;
    m_pos = IP; m_vis = 1; m_run = -1; m_prev = 0; m_moved = 0;

`ifdef SC_REGPLAYER_WRAP_EN
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 3, 'h18, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 7, 7, 'h81, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 'h03, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 'h03, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 7, 'h81, 1));
    tbl.push_back(mk(0, 1, 0, 0, 1, 5, 5, 'h60, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3, 'h00, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 3, 'h00, 0));
`else
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 3, 'h18, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 3, 'h18, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 4, 'h30, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 4, 'h30, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 3, 'h18, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 3, 'h00, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 3, 'h00, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 7, 6, 'hC0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 6, 'hC0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 5, 'h60, 1));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 5, 'h60, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 'h03, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 'h03, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 'h03, 0));
`endif

    @(negedge clk);
    foreach (tbl[i]) begin
      cycle(tbl[i].rst, tbl[i].clr_n, tbl[i].l, tbl[i].r, tbl[i].ld, tbl[i].lp, "vec");
      chk($sformatf("tbl%0d/pos", i),   32'(pos_o),   tbl[i].e_pos);
      chk($sformatf("tbl%0d/data", i),  32'(data_o),  tbl[i].e_data);
      chk($sformatf("tbl%0d/moved", i), 32'(moved_o), 32'(tbl[i].e_moved));
    end

    // Held left for 30 cycles from the reset position.
    cycle(1, 1, 0, 0, 0, 0, "hold_rst");
    mask = 0;
    for (int i = 0; i < 30; i++) begin
      cycle(0, 1, 1, 0, 0, 0, "hold");
      if (moved_o) mask = mask | (1 << i);
    end
    exp_mask = (1 << 0) | (1 << 16) | (1 << 20);
    if (WRAP) exp_mask = exp_mask | (1 << 24) | (1 << 28);
    chk("hold_mask", mask, exp_mask);
    chk("hold_final_pos", 32'(pos_o), WRAP ? 0 : 6);
    chk("hold_atleft", 32'(atl_o), WRAP ? 0 : 1);
    cycle(0, 1, 0, 0, 0, 0, "hold_rel");

    // Both directions held: no movement at all.
    cycle(1, 1, 0, 0, 0, 0, "both_rst");
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(0, 1, 1, 1, 0, 0, "both");
      if (moved_o) cnt++;
    end
    chk("both_moves", cnt, 0);
    chk("both_pos", 32'(pos_o), 3);

    // Right then left on consecutive edges: two immediate moves.
    cycle(0, 1, 0, 1, 0, 0, "sw_r");
    chk("sw_r_moved", 32'(moved_o), 1);
    chk("sw_r_pos", 32'(pos_o), 2);
    cycle(0, 1, 1, 0, 0, 0, "sw_l");
    chk("sw_l_moved", 32'(moved_o), 1);
    chk("sw_l_pos", 32'(pos_o), 3);
    cycle(0, 1, 0, 0, 0, 0, "sw_rel");

    // Reset in the middle of the initial delay, button still held.
    for (int i = 0; i < 5; i++) cycle(0, 1, 1, 0, 0, 0, "mid");
    cycle(1, 1, 1, 0, 0, 0, "mid_rst");
    chk("mid_rst_pos", 32'(pos_o), 3);
    chk("mid_rst_moved", 32'(moved_o), 0);
    cycle(0, 1, 1, 0, 0, 0, "mid_after");
    chk("mid_after_pos", 32'(pos_o), 4);
    chk("mid_after_moved", 32'(moved_o), 1);
    hold_pos = 32'(pos_o);
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 0, 0, "mid_hold");
    chk("mid_hold_pos", 32'(pos_o), hold_pos);

    // Random stimulus with sticky directions so repeat timing gets exercised.
    dir = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) dir = $urandom_range(0, 3);
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) != 0),
            dir[1], dir[0], ($urandom_range(0, 29) == 0), $urandom_range(0, 7), "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sc_regplayer_pos.md
# sc_regplayer_pos

Parametrised player-position register for the game datapath: holds a contiguous block of PLAYER_WIDTH lit bits inside a DATAWIDTH-bit display row and moves it left/right on button requests. Built-in press detection and hold-to-repeat timing let buttons drive it directly. Edge handling is clamp or wrap, selected at compile time. Output feeds the row driver and the collision logic.

## Interface
- DATAWIDTH, 8: row width in bits (≥ 4).
- PLAYER_WIDTH, 2: lit bits forming the player (1 … DATAWIDTH-1).
- INIT_POS, 3: index of the player's lowest bit after reset/clear.
- REPEAT_DELAY, 16: cycles a direction must be held before the first auto-repeat move (≥ 2).
- REPEAT_PERIOD, 4: cycles between subsequent auto-repeat moves (≥ 1).
- SC_REGPLAYER_CLOCK_50  in  1  system clock; all state changes on rising edge.
- SC_REGPLAYER_RESET_InHigh  in  1  synchronous, active-high reset.
- SC_REGPLAYER_clear_InLow  in  1  active-low: blank player, return to INIT_POS.
- SC_REGPLAYER_left_In  in  1  move request toward MSB, level (held = repeat).
- SC_REGPLAYER_right_In  in  1  move request toward LSB, level.
- SC_REGPLAYER_load_In  in  1  load position from loadpos, un-blank.
- SC_REGPLAYER_loadpos_InBUS  in  PW=$clog2(DATAWIDTH)  position to load.
- SC_REGPLAYER_data_OutBUS  out  DATAWIDTH  row pattern (registered).
- SC_REGPLAYER_pos_OutBUS  out  PW  current lowest-bit index (registered).
- SC_REGPLAYER_atleft_Out / SC_REGPLAYER_atright_Out  out  1 each  player at MSB / LSB limit (clamp mode only; 0 in wrap mode).
- SC_REGPLAYER_moved_Out  out  1  one-cycle pulse when position changed by a move.

## Operation
- State: pos (PW bits), visible flag, prev-direction register, repeat FSM {IDLE, DELAY, REPEAT}, repeat counter sized for max(REPEAT_DELAY, REPEAT_PERIOD).
- data_OutBUS = visible ? bits pos … pos+PLAYER_WIDTH-1 set (mod DATAWIDTH in wrap mode) : all zero. Registered with pos.
- Priority per edge: reset > clear low > load > move.
- Reset: pos=INIT_POS, visible=1, FSM IDLE, moved=0, prev-direction=none.
- Clear low: pos=INIT_POS, visible=0, FSM IDLE, moves ignored while low or while invisible.
- Load: pos = min(loadpos, POSMAX), visible=1, FSM IDLE, moved=0. POSMAX = DATAWIDTH-PLAYER_WIDTH (clamp) or DATAWIDTH-1 (wrap).
- Direction: exactly one of left/right high; both or none = no direction → FSM IDLE, counter cleared.
- IDLE + direction: move once, load counter REPEAT_DELAY-1, → DELAY.
- DELAY: counter decrements; at 0 move, load REPEAT_PERIOD-1, → REPEAT.
- REPEAT: counter decrements; at 0 move, reload REPEAT_PERIOD-1.
- Direction differs from previous cycle's direction (e.g. left→right without gap): treated as new press from IDLE (immediate move, DELAY).
- Move left: pos+1; right: pos-1. Clamp: blocked at POSMAX / 0 (pos unchanged, moved=0, FSM still advances). Wrap: pos modulo DATAWIDTH, player bits straddle MSB/LSB.
- moved_Out = 1 only in the cycle after an edge where pos actually changed by a move.

## Timing
- Move latency: direction sampled at edge k in IDLE → new pos/data visible after edge k; moved_Out high cycle k..k+1.
- Held request: moves at edges k, k+REPEAT_DELAY, then every REPEAT_PERIOD.
- Load/clear: effect visible after the sampling edge; single-cycle latency.
- Reset mid-repeat: everything returns to reset values after that edge; a still-held button moves on the first edge after reset deasserts.
- atleft/atright combinational from registered pos (no extra latency).

## Configuration
- SC_REGPLAYER_WRAP_EN defined: wrap-around edges, POSMAX = DATAWIDTH-1, atleft/atright tied 0.
- Undefined (default): clamp edges, POSMAX = DATAWIDTH-PLAYER_WIDTH, atleft = (pos==POSMAX), atright = (pos==0).

## Test plan
- Reset, defaults (clamp): data=8'b0001_1000, pos=3, atleft=0, atright=0, moved=0.
- Left single 1-cycle pulse: data=8'b0011_0000, pos=4, moved one cycle; no further move over 40 cycles.
- Left held 30 cycles from pos 3: moves at cycles 0,16,20,24,28 → clamps at pos 6 (8'b1100_0000, atleft=1); fourth attempt produces no moved pulse.
- Both left and right high 20 cycles: pos unchanged, moved never asserted; right-then-left switch with no gap moves twice on consecutive edges.
- Clear low, then left pulse: data=0, pos=3, no move; load with loadpos=7 (clamp) → pos=6, data=8'b1100_0000.
- WRAP_EN build: load pos=7, data=8'b1000_0001; left pulse → pos=0, data=8'b0000_0011, moved=1; reset asserted mid-DELAY → pos=3, FSM IDLE next cycle.
